// File: rtl/program_loader_if.sv
// Byte-stream in / program-memory write out bundle for the program loader.
`timescale 1ns/1ps
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ROM_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  START;
  logic [DATA_WIDTH-1:0] IN_DATA;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic                  WR_EN;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic [ROM_WIDTH-1:0]  WR_DATA;
  logic                  CPU_RST;
  logic                  DONE;
  logic                  ERR;

  modport master (
    output START, IN_DATA, IN_VALID,
    input  IN_READY, WR_EN, WR_ADDR, WR_DATA, CPU_RST, DONE, ERR
  );

  modport slave (
    input  START, IN_DATA, IN_VALID,
    output IN_READY, WR_EN, WR_ADDR, WR_DATA, CPU_RST, DONE, ERR
  );
endinterface

// File: rtl/program_loader.sv
// Loads a byte stream (opcode byte, immediate byte per word, then an XOR checksum)
// into program memory, holding the CPU in reset until a good load completes.
`timescale 1ns/1ps
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ROM_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  program_loader_if.slave  bus
);
  localparam int unsigned OPC_W = 4;
  localparam int unsigned IMM_W = ROM_WIDTH - OPC_W;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [OPC_W-1:0]      opc_q, opc_d;
  logic [IMM_W-1:0]      imm_q, imm_d;

  logic                  in_ready_q, wr_en_q, cpu_rst_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ROM_WIDTH-1:0]  wr_data_q;
  logic                  accept_c;

  assign accept_c = bus.IN_VALID && in_ready_q;

  // Next-state, counter, checksum and word-assembly logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    opc_d   = opc_q;
    imm_d   = imm_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.START) begin
          state_d = S_HI;
          addr_d  = '0;
          acc_d   = '0;
        end
      end
      S_HI: begin
        if (accept_c) begin
          acc_d   = acc_q ^ bus.IN_DATA;
          opc_d   = bus.IN_DATA[OPC_W-1:0];
          state_d = (bus.IN_DATA[DATA_WIDTH-1:OPC_W] != '0) ? S_ERR : S_LO;
        end
      end
      S_LO: begin
        if (accept_c) begin
          acc_d   = acc_q ^ bus.IN_DATA;
          imm_d   = IMM_W'(bus.IN_DATA);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The counter stops at the last address instead of wrapping.
        if (addr_q == LAST_ADDR) begin
          state_d = S_CHK;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_HI;
        end
      end
      S_CHK: begin
        if (accept_c) begin
          state_d = (bus.IN_DATA == acc_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the state being entered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      acc_q      <= '0;
      opc_q      <= '0;
      imm_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      cpu_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      opc_q      <= opc_d;
      imm_q      <= imm_d;
      in_ready_q <= state_d inside {S_HI, S_LO, S_CHK};
      wr_en_q    <= (state_d == S_WRITE);
      cpu_rst_q  <= state_d inside {S_HI, S_LO, S_WRITE, S_CHK, S_ERR};
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      wr_addr_q  <= addr_d;
      wr_data_q  <= {opc_d, imm_d};
    end
  end

  assign bus.IN_READY = in_ready_q;
  assign bus.WR_EN    = wr_en_q;
  assign bus.WR_ADDR  = wr_addr_q;
  assign bus.WR_DATA  = wr_data_q;
  assign bus.CPU_RST  = cpu_rst_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven load scenarios, hand-written corner
// sequences and randomized loads checked against a stream-level reference model.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int unsigned AW     = 4;
  localparam int unsigned RW     = 12;
  localparam int unsigned DW     = 8;
  localparam int unsigned NWORDS = 1 << AW;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst_n;

  program_loader_if #(.ADDR_WIDTH(AW), .ROM_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

  program_loader #(.ADDR_WIDTH(AW), .ROM_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stimulus stream, model results and observed results.
  byte_t            stim[$];
  bit               m_done, m_err;
  int               m_used;
  logic [RW-1:0]    m_w[$];
  logic [AW-1:0]    o_a[$];
  logic [RW-1:0]    o_d[$];
  int               r_used, r_edges;
  bit               r_done, r_err, r_timeout, r_cpu_bad, r_rdy_bad;

  // kind 0/1/2: fixed pattern (good / bad opcode / bad checksum); 3: random good;
  // 4: random with one bad opcode byte; 5: random with corrupted checksum.
  function automatic void gen_stim(input int kind);
    byte_t x;
    x = 8'h00;
    stim.delete();
    for (int i = 0; i < int'(NWORDS); i++) begin
      byte_t h, l;
      if (kind <= 2) begin
        h = byte_t'(i);
        l = byte_t'(8'h10 + i);
      end else begin
        h = byte_t'($urandom_range(0, 15));
        l = byte_t'($urandom_range(0, 255));
      end
      stim.push_back(h);
      stim.push_back(l);
      x = x ^ h ^ l;
    end
    stim.push_back(x);
    if (kind == 1) stim[0] = 8'h25;
    if (kind == 2) stim[2*NWORDS] = x ^ 8'h01;
    if (kind == 4) stim[2*$urandom_range(0, NWORDS-1)] =
        byte_t'(($urandom_range(1, 15) << 4) | $urandom_range(0, 15));
    if (kind == 5) stim[2*NWORDS] = x ^ byte_t'($urandom_range(1, 255));
  endfunction

  // Walks the byte stream word by word as the protocol describes it.
  function automatic void ref_model();
    byte_t sum;
    sum = 8'h00;
    m_w.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    m_used = 0;
    for (int i = 0; i < int'(NWORDS); i++) begin
      byte_t h, l;
      h = stim[2*i];
      l = stim[2*i+1];
      sum = sum ^ h;
      m_used++;
      if (h[7:4] != 4'h0) begin
        m_err = 1'b1;
        return;
      end
      sum = sum ^ l;
      m_used++;
      m_w.push_back({h[3:0], l});
    end
    m_used++;
    if (stim[2*NWORDS] == sum) m_done = 1'b1;
    else                       m_err  = 1'b1;
  endfunction

  // vmode 0: always valid, 1: valid every other cycle, 2: random valid.
  task automatic run_load(input int vmode, input int abort_addr, input bit lo_start);
    int idx;
    bit v;
    idx = 0;
    o_a.delete();
    o_d.delete();
    r_done = 0; r_err = 0; r_timeout = 1; r_cpu_bad = 0; r_rdy_bad = 0; r_edges = 0;
    bus.START    = 1'b1;
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    bus.START = 1'b0;
    for (int e = 0; e < 600; e++) begin
      if (bus.WR_EN) begin
        o_a.push_back(bus.WR_ADDR);
        o_d.push_back(bus.WR_DATA);
        if (bus.IN_READY) r_rdy_bad = 1'b1;
      end
      if (bus.DONE || bus.ERR) begin
        r_done = bus.DONE; r_err = bus.ERR; r_edges = e; r_timeout = 0;
        break;
      end
      if (!bus.CPU_RST) r_cpu_bad = 1'b1;
      if (abort_addr >= 0 && bus.WR_EN && int'(bus.WR_ADDR) == abort_addr) begin
        r_timeout = 0;
        break;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (e % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (idx >= stim.size()) v = 1'b0;
      bus.IN_VALID = v;
      bus.IN_DATA  = (idx < stim.size()) ? stim[idx] : 8'h00;
      bus.START    = lo_start && (e == 1);
      if (v && bus.IN_READY) idx++;
      @(negedge clk);
    end
    bus.IN_VALID = 1'b0;
    bus.START    = 1'b0;
    r_used       = idx;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_timeout"}, 32'(r_timeout), 32'd0);
    check({tag, "_done"}, 32'(r_done), 32'(m_done));
    check({tag, "_err"}, 32'(r_err), 32'(m_err));
    check({tag, "_bytes"}, 32'(r_used), 32'(m_used));
    check({tag, "_nwr"}, 32'(o_d.size()), 32'(m_w.size()));
    for (int i = 0; i < o_d.size() && i < m_w.size(); i++)
      check({tag, "_word"}, 32'({o_a[i], o_d[i]}), 32'({AW'(i), m_w[i]}));
    check({tag, "_cpu_rst_held"}, 32'(r_cpu_bad), 32'd0);
    check({tag, "_cpu_rst_end"}, 32'(bus.CPU_RST), 32'(r_err));
    check({tag, "_ready_in_write"}, 32'(r_rdy_bad), 32'd0);
  endtask

  typedef struct {
    int kind;
    int vmode;
    bit exp_done;
    bit exp_err;
    int exp_nwr;
    int exp_edges;
  } vec_t;

  initial begin
    vec_t vec[6];
    int   wr_seen;

    vec[0] = '{0, 0, 1'b1, 1'b0, 16, 49};
    vec[1] = '{1, 0, 1'b0, 1'b1, 0,  1};
    vec[2] = '{2, 0, 1'b0, 1'b1, 16, 49};
    vec[3] = '{0, 1, 1'b1, 1'b0, 16, 65};
    vec[4] = '{2, 1, 1'b0, 1'b1, 16, 65};
    vec[5] = '{1, 2, 1'b0, 1'b1, 0,  -1};

    rst_n        = 1'b0;
    bus.START    = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({bus.IN_READY, bus.WR_EN, bus.CPU_RST, bus.DONE, bus.ERR}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", 32'({bus.IN_READY, bus.WR_EN, bus.CPU_RST, bus.DONE, bus.ERR}), 32'd0);

    for (int t = 0; t < 6; t++) begin
      gen_stim(vec[t].kind);
      ref_model();
      run_load(vec[t].vmode, -1, 1'b0);
      check("vec_done", 32'(r_done), 32'(vec[t].exp_done));
      check("vec_err", 32'(r_err), 32'(vec[t].exp_err));
      check("vec_nwr", 32'(o_d.size()), 32'(vec[t].exp_nwr));
      if (vec[t].exp_edges >= 0) check("vec_cycles", 32'(r_edges), 32'(vec[t].exp_edges));
      if (vec[t].kind != 1)
        for (int i = 0; i < o_d.size(); i++)
          check("vec_pattern", 32'(o_d[i]), 32'({4'(i), 8'(8'h10 + i)}));
      compare_model("vec");
    end

    // DONE and the released CPU hold until the next START.
    gen_stim(0);
    ref_model();
    run_load(0, -1, 1'b0);
    repeat (5) @(negedge clk);
    check("done_hold", 32'({bus.DONE, bus.ERR, bus.CPU_RST, bus.IN_READY, bus.WR_EN}), 32'b10000);

    // Reset mid-load after word 5 is written, then a clean reload from address 0.
    gen_stim(0);
    run_load(0, 5, 1'b0);
    check("abort_nwr", 32'(o_d.size()), 32'd6);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset_outs",
             32'({bus.IN_READY, bus.WR_EN, bus.CPU_RST, bus.DONE, bus.ERR}), 32'd0);
    wr_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.WR_EN) wr_seen++;
    end
    check("no_write_in_reset", 32'(wr_seen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    ref_model();
    run_load(0, -1, 1'b0);
    check("reload_cycles", 32'(r_edges), 32'd49);
    compare_model("reload");

    // START while in LO is ignored.
    gen_stim(0);
    ref_model();
    run_load(0, -1, 1'b1);
    check("lo_start_cycles", 32'(r_edges), 32'd49);
    compare_model("lo_start");

    for (int n = 0; n < 12; n++) begin
      gen_stim(int'($urandom_range(3, 5)));
      ref_model();
      run_load(2, -1, 1'b0);
      compare_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
- REQ-001 SHALL have parameter ADDR_WIDTH, default 4, program memory address width (depth 2**ADDR_WIDTH words).
- REQ-002 SHALL have parameter ROM_WIDTH, default 12, instruction word width: 4-bit opcode in [11:8], 8-bit immediate in [7:0].
- REQ-003 SHALL have parameter DATA_WIDTH, default 8, byte-stream width.
- REQ-004 SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
- REQ-005 SHALL have port RST, input, 1, asynchronous, active-low reset.
- REQ-006 SHALL have port START, input, 1, load request, sampled each cycle.
- REQ-007 SHALL have port IN_DATA, input, DATA_WIDTH, incoming program byte.
- REQ-008 SHALL have port IN_VALID, input, 1, IN_DATA valid.
- REQ-009 SHALL have port IN_READY, output, 1, loader accepts a byte this cycle.
- REQ-010 SHALL have port WR_EN, output, 1, program memory write strobe.
- REQ-011 SHALL have port WR_ADDR, output, ADDR_WIDTH, write address.
- REQ-012 SHALL have port WR_DATA, output, ROM_WIDTH, instruction word to write.
- REQ-013 SHALL have port CPU_RST, output, 1, active-high hold-in-reset for program counter; OR'd with the system reset.
- REQ-014 SHALL have port DONE, output, 1, load completed with a good checksum.
- REQ-015 SHALL have port ERR, output, 1, load aborted on a format or checksum error.

Function
- REQ-016 SHALL implement a state machine with states IDLE, HI, LO, WRITE, CHK, DONE, ERR.
- REQ-017 SHALL accept a byte only when IN_VALID and IN_READY are both 1 at a rising CLK edge.
- REQ-018 SHALL drive IN_READY as a pure function of state: 1 in HI, LO and CHK; 0 in all other states.
- REQ-019 SHALL go from IDLE, DONE or ERR to HI on START=1, clearing the address counter to 0 and the XOR checksum accumulator to 0x00; START in any other state SHALL be ignored.
- REQ-020 In HI, an accepted byte SHALL be XORed into the accumulator; bits [3:0] SHALL be stored as the opcode, with a transition to LO if bits [7:4]==0 and to ERR otherwise.
- REQ-021 In LO, an accepted byte SHALL be XORed into the accumulator and stored as the immediate, with a transition to WRITE.
- REQ-022 In WRITE, WR_EN SHALL be 1 for exactly one cycle, with WR_ADDR = address counter and WR_DATA = {opcode, immediate}.
- REQ-023 WRITE SHALL go to CHK if the address counter equals 2**ADDR_WIDTH-1; otherwise it SHALL increment the counter and go to HI.
- REQ-024 The address counter SHALL never wrap during a load.
- REQ-025 WR_EN SHALL be 0 in every state other than WRITE; WR_ADDR and WR_DATA are don't-care when WR_EN=0.
- REQ-026 In CHK, an accepted byte equal to the accumulator SHALL go to DONE; any other value SHALL go to ERR.
- REQ-027 CPU_RST SHALL be 1 in HI, LO, WRITE, CHK and ERR, and 0 in IDLE and DONE.
- REQ-028 DONE SHALL be 1 only in the DONE state; ERR SHALL be 1 only in the ERR state; both SHALL hold until the next START.
- REQ-029 With IN_VALID=0, the loader SHALL wait indefinitely in HI, LO or CHK with no state change.
- REQ-030 Minimum load time SHALL be 3 cycles per word plus 1 checksum cycle: 49 cycles for 16 words.

Reset
- REQ-031 While RST=0, state SHALL be IDLE, the address counter, accumulator, opcode and immediate SHALL be 0, and IN_READY=0, WR_EN=0, CPU_RST=0, DONE=0, ERR=0.
- REQ-032 RST assertion mid-load SHALL abort immediately with no further write strobes; memory contents already written are undefined as a program.
- REQ-033 Outputs SHALL change only on the rising CLK edge after RST deasserts.

Verification
- REQ-034 Full load: START, then 16 word pairs (0x0i, 0x10+i) with IN_VALID held 1, then the correct XOR byte -> 16 WR_EN pulses at addresses 0..15 with WR_DATA = {i, 0x10+i}, DONE=1 at cycle 49, CPU_RST falls with DONE.
- REQ-035 Bad opcode byte: first byte 0x25 -> ERR=1 and CPU_RST stays 1 with no WR_EN pulse; a following START restarts from address 0.
- REQ-036 Bad checksum: correct 32 bytes, checksum XOR 0x01 -> 16 writes then ERR=1, DONE=0.
- REQ-037 Backpressure: IN_VALID toggled 1/0 every cycle -> identical write sequence to REQ-034; no byte dropped or duplicated.
- REQ-038 Reset mid-load: RST=0 after word 5 is written -> all outputs 0 asynchronously, no WR_EN afterward; START after release loads from address 0.
- REQ-039 START while in LO -> ignored; the load completes normally.
